// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master on the ZXUNO register bus (START/STOP/WRITE/READ commands).
// Latency: command accepted on the write edge, busy the next cycle; START/STOP 4*CLKDIV, WRITE/READ 36*CLKDIV cycles.
// Backpressure: none on the bus; command and data writes arriving while busy are dropped, software polls busy.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   zxuno_addr/regrd/regwr/din ZXUNO register access (CMDREG = command/status, DATAREG = data)
//   dout, oe                   combinational read data and read-enable
//   sck, sda                   open-drain I2C lines (driven low or released)
module i2c_byte_master #(
    parameter logic [7:0]  CMDREG  = 8'hEB,
    parameter logic [7:0]  DATAREG = 8'hEC,
    parameter int unsigned CLKDIV  = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe,
    output wire        sck,
    inout  wire        sda
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_STOP,
        S_XFER
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    state_t     state;
    logic [1:0] quarter;     // q0..q3 within the current step
    logic [3:0] bitn;        // XFER bit slot 0..8
    logic [7:0] div;         // quarter-period divider
    logic       rsck;
    logic       rsda;
    logic       busy;
    logic       ack_rx;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       is_read;     // current XFER is a READ
    logic       mack;        // master ACK bit sent in slot 8 of a READ

    logic       tick;
    logic       cmd_wr;
    logic       data_wr;
    logic       sda_in;
    logic       outbit;
    logic       last_quarter;

    // Open-drain pads: only ever pull low, otherwise release to the pull-up.
    assign sck = rsck ? 1'bz : 1'b0;
    assign sda = rsda ? 1'bz : 1'b0;

    // Anything that is not a solid 0 (released, pulled up) reads as 1.
    assign sda_in = (sda === 1'b0) ? 1'b0 : 1'b1;

    assign tick    = (div == DIV_LAST);
    assign cmd_wr  = zxuno_regwr && (zxuno_addr == CMDREG);
    assign data_wr = zxuno_regwr && (zxuno_addr == DATAREG);

    // Step completes on q3: START/STOP have one step, XFER has nine slots.
    assign last_quarter = (quarter == 2'd3) && ((state != S_XFER) || (bitn == 4'd8));

    // Bit placed on SDA at q0 of each XFER slot.
    always_comb begin
        outbit = 1'b1;
        if (bitn == 4'd8) begin
            outbit = is_read ? mack : 1'b1;
        end else if (!is_read) begin
            outbit = tx_data[3'd7 - bitn[2:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            quarter <= 2'd0;
            bitn    <= 4'd0;
            div     <= 8'd0;
            rsck    <= 1'b1;
            rsda    <= 1'b1;
            busy    <= 1'b0;
            ack_rx  <= 1'b0;
            rx_data <= 8'h00;
            tx_data <= 8'h00;
            is_read <= 1'b0;
            mack    <= 1'b1;
        end else if (state == S_IDLE) begin
            // Divider parked at 0 so the first quarter of a command is a full CLKDIV.
            div <= 8'd0;
            if (data_wr) begin
                tx_data <= din;
            end
            if (cmd_wr) begin
                busy    <= 1'b1;
                quarter <= 2'd0;
                bitn    <= 4'd0;
                mack    <= din[2];
                is_read <= (din[1:0] == 2'b01);
                case (din[1:0])
                    2'b10:   state <= S_START;
                    2'b11:   state <= S_STOP;
                    default: state <= S_XFER;
                endcase
            end
        end else begin
            div <= tick ? 8'd0 : div + 8'd1;
            if (tick) begin
                quarter <= quarter + 2'd1;
                case (state)
                    S_START: begin
                        // SDA high -> SCL high -> SDA falls under high SCL -> SCL low.
                        // Works from SCL low too, which gives a repeated start.
                        case (quarter)
                            2'd0:    rsda <= 1'b1;
                            2'd1:    rsck <= 1'b1;
                            2'd2:    rsda <= 1'b0;
                            default: rsck <= 1'b0;
                        endcase
                    end
                    S_STOP: begin
                        case (quarter)
                            2'd0:    rsda <= 1'b0;
                            2'd1:    rsck <= 1'b1;
                            2'd2:    rsda <= 1'b1;
                            default: ;
                        endcase
                    end
                    S_XFER: begin
                        case (quarter)
                            2'd0:    rsda <= outbit;
                            2'd1:    rsck <= 1'b1;
                            2'd2: begin
                                // Sample in the middle of the SCL high phase.
                                if (bitn == 4'd8) begin
                                    if (!is_read) begin
                                        ack_rx <= sda_in;
                                    end
                                end else if (is_read) begin
                                    rx_data <= {rx_data[6:0], sda_in};
                                end
                            end
                            default: begin
                                rsck <= 1'b0;
                                if (bitn != 4'd8) begin
                                    bitn <= bitn + 4'd1;
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
                if (last_quarter) begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            end
        end
    end

    // Register reads; busy on bit 7 lets the CPU test it with the sign flag.
    always_comb begin
        dout = 8'h00;
        oe   = 1'b0;
        if (zxuno_addr == CMDREG) begin
            dout = {busy, ack_rx, 6'b000000};
            oe   = zxuno_regrd;
        end else if (zxuno_addr == DATAREG) begin
            dout = rx_data;
            oe   = zxuno_regrd;
        end
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: bench for i2c_byte_master with CLKDIV=4.
// Keeps a quarter-level waveform model of each command plus a behavioural slave on SDA.
// Checks pins and register reads every cycle, plus hand-computed literals per scenario.
module tb_i2c_byte_master;

    localparam int         C       = 4;
    localparam logic [7:0] CMDREG  = 8'hEB;
    localparam logic [7:0] DATAREG = 8'hEC;
    localparam logic [1:0] K_WR    = 2'b00;
    localparam logic [1:0] K_RD    = 2'b01;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr  = CMDREG;
    logic       regrd = 1'b1;
    logic       regwr = 1'b0;
    logic [7:0] din   = 8'h00;
    logic [7:0] dout;
    logic       oe;
    wire        sck_w;
    wire        sda_w;
    logic       slave_low = 1'b0;

    pullup (sck_w);
    pullup (sda_w);
    assign sda_w = slave_low ? 1'b0 : 1'bz;

    i2c_byte_master #(
        .CMDREG (CMDREG),
        .DATAREG(DATAREG),
        .CLKDIV (C)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .zxuno_addr (addr),
        .zxuno_regrd(regrd),
        .zxuno_regwr(regwr),
        .din        (din),
        .dout       (dout),
        .oe         (oe),
        .sck        (sck_w),
        .sda        (sda_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic       cur_sck = 1'b1, cur_sda = 1'b1, cur_ack = 1'b0;
    logic [7:0] cur_rx = 8'h00, m_tx = 8'h00;
    logic       m_act = 1'b0;
    logic [1:0] m_kind = 2'b10;
    int         acc_cyc = 0;
    int         total = 4;
    logic       tbl_sck [0:36];
    logic       tbl_sda [0:36];
    logic       n_ack = 1'b0;
    logic [7:0] n_rx = 8'h00;
    logic       slave_ack = 1'b0;
    logic [7:0] slave_byte = 8'h00;

    // Elapsed quarter ticks of the current command (one tick per C cycles).
    function automatic int cur_t();
        int t;
        if (!m_act) return 0;
        t = (cyc - acc_cyc) / C;
        if (t > total) t = total;
        return t;
    endfunction

    // Slave: ACKs slot 8 of a WRITE, or presents its byte MSB-first during a READ.
    function automatic logic slave_calc(input int t);
        int n;
        if (!m_act || t >= total) return 1'b0;
        n = t / 4;
        if (m_kind == K_WR) return slave_ack && (n == 8);
        if (m_kind == K_RD) return (n < 8) && !slave_byte[7-n];
        return 1'b0;
    endfunction

    // Master line levels after each quarter, straight from the command's quarter table.
    task automatic build(input logic mk);
        logic s, d;
        int   n, q;
        s = cur_sck;
        d = cur_sda;
        tbl_sck[0] = s;
        tbl_sda[0] = d;
        for (int j = 0; j < total; j++) begin
            n = j / 4;
            q = j % 4;
            case (m_kind)
                2'b10: begin
                    if (q == 0) d = 1'b1;
                    if (q == 1) s = 1'b1;
                    if (q == 2) d = 1'b0;
                    if (q == 3) s = 1'b0;
                end
                2'b11: begin
                    if (q == 0) d = 1'b0;
                    if (q == 1) s = 1'b1;
                    if (q == 2) d = 1'b1;
                end
                default: begin
                    if (q == 0) begin
                        if (m_kind == K_WR) d = (n < 8) ? m_tx[7-n] : 1'b1;
                        else                d = (n < 8) ? 1'b1 : mk;
                    end
                    if (q == 1) s = 1'b1;
                    if (q == 3) s = 1'b0;
                end
            endcase
            tbl_sck[j+1] = s;
            tbl_sda[j+1] = d;
        end
        n_ack = (m_kind == K_WR) ? ~slave_ack : cur_ack;
        n_rx  = (m_kind == K_RD) ? slave_byte : cur_rx;
    endtask

    task automatic finalize();
        if (m_act) begin
            cur_sck = tbl_sck[total];
            cur_sda = tbl_sda[total];
            cur_ack = n_ack;
            cur_rx  = n_rx;
            m_act   = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        #2;
        slave_low = slave_calc(cur_t());
    end

    // ---------------- capture of SDA at each SCL rise ----------------
    logic [8:0] cap = 9'h0;
    int         cap_n = 0;
    logic       prev_sck = 1'b1;
    always @(negedge clk) begin
        if (sck_w === 1'b1 && prev_sck === 1'b0) begin
            cap = {cap[7:0], sda_w};
            cap_n++;
        end
        prev_sck = sck_w;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        int         t;
        logic       ebusy, esck, esda, eack;
        logic [7:0] erx;
        t     = cur_t();
        ebusy = m_act && (t < total);
        esck  = m_act ? tbl_sck[t] : cur_sck;
        esda  = (m_act ? tbl_sda[t] : cur_sda) & ~slave_low;
        eack  = (m_act && !ebusy) ? n_ack : cur_ack;
        erx   = (m_act && !ebusy) ? n_rx : cur_rx;
        check("sck_line", 32'(sck_w), 32'(esck));
        check("sda_line", 32'(sda_w), 32'(esda));
        check("oe", 32'(oe), 32'(regrd && (addr == CMDREG || addr == DATAREG)));
        if (regrd) begin
            if (addr == CMDREG) begin
                if (ebusy && m_kind == K_WR) check("status_busy", 32'(dout[7]), 32'(ebusy));
                else check("status", 32'(dout), 32'({ebusy, eack, 6'b0}));
            end else if (addr == DATAREG) begin
                if (!(ebusy && m_kind == K_RD)) check("rx_data", 32'(dout), 32'(erx));
            end else begin
                check("dout_other", 32'(dout), 32'h0);
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_cmd(input logic [7:0] d);
        finalize();
        @(posedge clk); #1;
        addr = CMDREG; din = d; regwr = 1'b1; regrd = 1'b0;
        @(posedge clk); #1;
        regwr   = 1'b0; regrd = 1'b1;
        m_kind  = d[1:0];
        total   = d[1] ? 4 : 36;
        acc_cyc = cyc;
        build(d[2]);
        m_act   = 1'b1;
        cap     = 9'h0;
        cap_n   = 0;
    endtask

    task automatic wr_data(input logic [7:0] d);
        @(posedge clk); #1;
        addr = DATAREG; din = d; regwr = 1'b1; regrd = 1'b0;
        @(posedge clk); #1;
        regwr = 1'b0; regrd = 1'b1; addr = CMDREG;
        m_tx  = d;
    endtask

    // Register write the DUT must drop (issued while busy).
    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        addr = a; din = d; regwr = 1'b1; regrd = 1'b0;
        @(posedge clk); #1;
        regwr = 1'b0; regrd = 1'b1; addr = CMDREG;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v, output logic o);
        @(posedge clk); #1;
        addr = a; regrd = 1'b1;
        @(negedge clk);
        v = dout;
        o = oe;
        @(posedge clk); #1;
        addr = CMDREG;
    endtask

    task automatic wait_until_t(input int k);
        int g;
        g = 0;
        while (cur_t() < k && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) check("wait_timeout", 32'(g), 32'(0));
    endtask

    // Counts busy cycles seen on status bit 7; mid_stat is the status 3 cycles in.
    task automatic wait_done(input string name, input int exp_busy, output logic [7:0] mid_stat);
        int n, g;
        n = 0;
        g = 0;
        mid_stat = 8'h00;
        while (cur_t() < total && g < 2000) begin
            @(negedge clk);
            if (g == 3) mid_stat = dout;
            if (dout[7]) n++;
            g++;
        end
        if (g >= 2000) check({name, "_timeout"}, 32'(g), 32'(0));
        if (exp_busy >= 0) check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    endtask

    logic [7:0] v, mid;
    logic       o;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        rd(CMDREG, v, o);   check("rst_status", 32'(v), 32'h00); check("rst_oe_cmd", 32'(o), 32'h1);
        rd(DATAREG, v, o);  check("rst_rx", 32'(v), 32'h00);
        rd(8'h10, v, o);    check("other_dout", 32'(v), 32'h00); check("other_oe", 32'(o), 32'h0);
        check("rst_sck", 32'(sck_w), 32'h1);
        check("rst_sda", 32'(sda_w), 32'h1);

        // START from idle.
        do_cmd(8'h02);
        wait_done("start", 16, mid);
        check("start_mid_status", 32'(mid), 32'h80);
        check("start_end_sck", 32'(sck_w), 32'h0);
        check("start_end_sda", 32'(sda_w), 32'h0);
        rd(CMDREG, v, o);   check("start_status", 32'(v), 32'h00);

        // WRITE 0xA5, slave ACKs.
        wr_data(8'hA5);
        slave_ack = 1'b1;
        do_cmd(8'h00);
        wait_done("wr_ack", 144, mid);
        check("wr_ack_bits", 32'(cap[8:1]), 32'hA5);
        check("wr_ack_slot8", 32'(cap[0]), 32'h0);
        check("wr_ack_rises", 32'(cap_n), 32'd9);
        rd(CMDREG, v, o);   check("wr_ack_status", 32'(v), 32'h00);

        // WRITE with no slave.
        slave_ack = 1'b0;
        do_cmd(8'h00);
        wait_done("wr_nack", 144, mid);
        rd(CMDREG, v, o);   check("wr_nack_status", 32'(v), 32'h40);

        // READ with master NACK, slave sends 0x3C.
        slave_byte = 8'h3C;
        do_cmd(8'h05);
        wait_done("rd", 144, mid);
        check("rd_line_bits", 32'(cap[8:1]), 32'h3C);
        check("rd_slot8_released", 32'(cap[0]), 32'h1);
        rd(DATAREG, v, o);  check("rd_data", 32'(v), 32'h3C);
        rd(CMDREG, v, o);   check("rd_status", 32'(v), 32'h40);

        // Writes while busy are dropped.
        slave_ack = 1'b1;
        do_cmd(8'h00);
        wait_until_t(5);
        poke(CMDREG, 8'h03);
        poke(DATAREG, 8'hFF);
        wait_done("ign", -1, mid);
        check("ign_bits", 32'(cap[8:1]), 32'hA5);
        rd(CMDREG, v, o);   check("ign_status", 32'(v), 32'h00);
        do_cmd(8'h00);
        wait_done("ign2", 144, mid);
        check("ign_tx_kept", 32'(cap[8:1]), 32'hA5);

        // Reset in slot 4 of a WRITE.
        slave_ack = 1'b0;
        do_cmd(8'h00);
        wait_until_t(17);
        @(posedge clk); #3;
        m_act = 1'b0; cur_sck = 1'b1; cur_sda = 1'b1; cur_ack = 1'b0; cur_rx = 8'h00; m_tx = 8'h00;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sck", 32'(sck_w), 32'h1);
        check("mid_rst_sda", 32'(sda_w), 32'h1);
        check("mid_rst_status", 32'(dout), 32'h00);
        @(posedge clk); #1 rst_n = 1'b1;

        // START then STOP after the reset.
        do_cmd(8'h02);
        wait_done("start2", 16, mid);
        do_cmd(8'h03);
        wait_done("stop", 16, mid);
        check("stop_mid_status", 32'(mid), 32'h80);
        check("stop_end_sck", 32'(sck_w), 32'h1);
        check("stop_end_sda", 32'(sda_w), 32'h1);
        rd(CMDREG, v, o);   check("stop_status", 32'(v), 32'h00);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
Hardware byte-level I2C master on the ZXUNO register bus. It is the companion stage to the bit-bang I2C register: it drives the same open-drain SCK/SDA pair, but from queued commands instead of CPU-toggled bits. The CPU issues START, STOP, WRITE-byte and READ-byte commands through a command register, then polls busy and ACK status. Data moves through a separate data register.

Parameters:
CMDREG, 8'hEB, ZXUNO register address of the command/status register
DATAREG, 8'hEC, ZXUNO register address of the data register
CLKDIV, 63, clk cycles per SCL quarter-period; legal range 2..255 (one SCL period = 4*CLKDIV cycles)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
zxuno_addr  in  8  ZXUNO register address
zxuno_regrd  in  1  register read strobe
zxuno_regwr  in  1  register write strobe
din  in  8  write data
dout  out  8  read data (combinational)
oe  out  1  high while either register is being read (combinational)
sck  out  1  open-drain SCL: driven 0 when the internal rsck is 0, otherwise z
sda  inout  1  open-drain SDA: driven 0 when the internal rsda is 0, otherwise z; any non-0 input value is sampled as 1

Behaviour:
- Reset: async, active-low.
  - rsck=1, rsda=1 (bus released); busy=0, ack_rx=0, rx_data=0, tx_data=0.
  - State machine returns to IDLE; divider and bit counters are cleared.
  - A reset in mid-transfer releases both lines immediately and does not complete the transfer.
- Write to DATAREG (addr match and regwr): tx_data <= din. Ignored while busy=1.
- Write to CMDREG while busy=0 starts a command; ignored while busy=1.
  - din[1:0] selects the command: 00 WRITE, 01 READ, 10 START, 11 STOP.
  - din[2] is the master ACK bit sent after a READ (0=ACK, 1=NACK).
  - busy goes to 1 on the cycle after the write.
  - The quarter divider restarts at 0, so every quarter lasts exactly CLKDIV cycles.
- Quarter tick: the divider counts 0..CLKDIV-1 and ticks at CLKDIV-1. All line changes and samples happen on ticks.
- States: IDLE, START, STOP, XFER. Quarters q0..q3 within a step:
  - START: q0 rsda=1; q1 rsck=1; q2 rsda=0; q3 rsck=0.
    - Entering START with SCL low is a valid repeated start.
    - Busy duration: 4*CLKDIV cycles.
  - STOP: q0 rsda=0; q1 rsck=1; q2 rsda=1; q3 hold; then IDLE with both lines released.
    - Busy duration: 4*CLKDIV cycles.
  - XFER runs 9 bit slots (bit counter 0..8), each slot q0 rsda=outbit; q1 rsck=1; q2 sample sda; q3 rsck=0.
    - WRITE: outbit = tx_data[7-n] for n=0..7, 1 (released) for n=8. The n=8 sample goes to ack_rx (0 = slave ACK).
    - READ: outbit = 1 for n=0..7, with samples shifted MSB-first into rx_data; outbit = the latched din[2] for n=8. ack_rx is unchanged.
    - Busy duration: 36*CLKDIV cycles. XFER leaves SCL low and SDA per the last slot's q0 value.
  - After the final quarter: busy=0, return to IDLE. rx_data and ack_rx are updated no later than the cycle busy falls.
- Clock stretching is not supported; SCL is never read back.
- Reads (combinational):
  - CMDREG returns {busy, ack_rx, 6'b0}; busy sits at bit 7 so JP P / JP M can test it.
  - DATAREG returns rx_data.
  - Any other address: dout=0, oe=0.
- A simultaneous CMDREG write and tick in IDLE needs no special handling; the divider is cleared on accept.
- WRITE/READ issued without a prior START is executed as-is; protocol sequencing is the software's responsibility.

Test Plan:
- CLKDIV=4, START from idle -> busy high for 16 cycles; SDA falls while SCK is high at ~cycle 12; SCK low at the end; CMDREG reads 8'h80 while busy and 8'h00 after.
- tx_data=8'hA5, WRITE, slave model pulls SDA low on slot 8 -> SDA sampled at each SCK rise is 1,0,1,0,0,1,0,1; busy lasts 144 cycles; ack_rx=0; CMDREG reads 8'h00.
- Same WRITE with no slave (pull-up only) -> ack_rx=1; CMDREG reads 8'h40.
- READ with din[2]=1, slave drives 8'h3C -> DATAREG reads 8'h3C; SDA is released (1) during slot 8; rsda is never 0 during slots 0..7.
- During a WRITE, a STOP write to CMDREG and a DATAREG write of 8'hFF -> both ignored; the transfer completes with the original byte; tx_data is unchanged.
- rst_n pulsed low mid-byte (slot 4) -> sck/sda go to z immediately; busy=0; a following START/STOP runs normally.
